multicycle_ctrl_unit: RTL and testbench

Multicycle MIPS control unit: a Moore FSM that sequences each instruction over 3–5+ cycles through a shared memory, a single ALU and architectural registers (PC, IR, ALUOut, MDR) that live in the datapath. It is the multicycle successor to the single-cycle control unit and keeps its ALU control encoding. It adds a memory wait-state parameter and optional `bne` support. It sits between the instruction register (sources `op_code`/`funct`) and the multicycle datapath.

---
 rtl/multicycle_ctrl_unit.sv | 124 ++++++++++++
 tb/tb_multicycle_ctrl_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: Moore FSM sequencing multicycle MIPS instructions with memory wait states
module multicycle_ctrl_unit #(
  parameter int MEM_LAT = 1,
  parameter bit EN_BNE  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       redest,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alu_ctrl,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  localparam int CW = $clog2(MEM_LAT) + 1;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(MEM_LAT - 1);
  assign state_o = state;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : last ? cnt : cnt + CW'(1);
    end
  always_comb begin
    state_nxt = FETCH;
    iord      = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    pcen      = 1'b0;
    regwrite  = 1'b0;
    redest    = 1'b0;
    memtoreg  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    alu_ctrl  = 3'b010;
    case (state)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite   = last;
        pcen      = last;
        state_nxt = last ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb   = 2'b11;
        state_nxt = (op_code == 6'b100011 || op_code == 6'b101011) ? MEMADR :
                    (op_code == 6'b000000) ? EXEC :
                    (op_code == 6'b001000) ? ADDIEX :
                    (op_code == 6'b000100 || (EN_BNE && op_code == 6'b000101)) ? BRANCH :
                    (op_code == 6'b000010) ? JUMP : FETCH;
      end
      MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = (op_code == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord      = 1'b1;
        state_nxt = last ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        memwrite  = last;
        state_nxt = last ? FETCH : MEMWR;
      end
      EXEC: begin
        alusrca   = 1'b1;
        alu_ctrl  = (funct == 6'b100010) ? 3'b100 :
                    (funct == 6'b101010) ? 3'b110 :
                    (funct == 6'b011100) ? 3'b101 : 3'b010;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        regwrite = 1'b1;
        redest   = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        alu_ctrl = 3'b100;
        pcsrc    = 2'b01;
        pcen     = (EN_BNE && op_code == 6'b000101) ? ~zero : zero;
      end
      ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = ADDIWB;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // reset masks strobes even though FETCH with MEM_LAT=1 would raise irwrite/pcen
    if (reset) begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// tb_multicycle_ctrl_unit: table-driven checks of the multicycle control FSM across three parameter sets
module tb_multicycle_ctrl_unit;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] op_code = 6'd0, funct = 6'd0;
  always #5 clk = ~clk;

  // packed view: {iord,memwrite,irwrite,pcen,regwrite,redest,memtoreg,alusrca,alusrcb,pcsrc,alu_ctrl,state}
  localparam logic [18:0] FT0  = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 4'd0};
  localparam logic [18:0] FT1  = {8'b0011_0000, 2'b01, 2'b00, 3'b010, 4'd0};
  localparam logic [18:0] DEC  = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 4'd1};
  localparam logic [18:0] MAD  = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 4'd2};
  localparam logic [18:0] MRD  = {8'b1000_0000, 2'b00, 2'b00, 3'b010, 4'd3};
  localparam logic [18:0] MWB  = {8'b0000_1010, 2'b00, 2'b00, 3'b010, 4'd4};
  localparam logic [18:0] MWR0 = {8'b1000_0000, 2'b00, 2'b00, 3'b010, 4'd5};
  localparam logic [18:0] MWR1 = {8'b1100_0000, 2'b00, 2'b00, 3'b010, 4'd5};
  localparam logic [18:0] EXA  = {8'b0000_0001, 2'b00, 2'b00, 3'b010, 4'd6};
  localparam logic [18:0] EXS  = {8'b0000_0001, 2'b00, 2'b00, 3'b100, 4'd6};
  localparam logic [18:0] EXT  = {8'b0000_0001, 2'b00, 2'b00, 3'b101, 4'd6};
  localparam logic [18:0] AWB  = {8'b0000_1100, 2'b00, 2'b00, 3'b010, 4'd7};
  localparam logic [18:0] BR1  = {8'b0001_0001, 2'b00, 2'b01, 3'b100, 4'd8};
  localparam logic [18:0] BR0  = {8'b0000_0001, 2'b00, 2'b01, 3'b100, 4'd8};
  localparam logic [18:0] AIE  = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 4'd9};
  localparam logic [18:0] AIW  = {8'b0000_1000, 2'b00, 2'b00, 3'b010, 4'd10};
  localparam logic [18:0] JMP  = {8'b0001_0000, 2'b00, 2'b10, 3'b010, 4'd11};

  logic [18:0] oa, ob, oc;
  logic a_iord, a_mw, a_irw, a_pcen, a_rw, a_rd, a_m2r, a_asa;
  logic b_iord, b_mw, b_irw, b_pcen, b_rw, b_rd, b_m2r, b_asa;
  logic c_iord, c_mw, c_irw, c_pcen, c_rw, c_rd, c_m2r, c_asa;
  logic [1:0] a_asb, a_pcs, b_asb, b_pcs, c_asb, c_pcs;
  logic [2:0] a_alu, b_alu, c_alu;
  logic [3:0] a_st, b_st, c_st;
  assign oa = {a_iord, a_mw, a_irw, a_pcen, a_rw, a_rd, a_m2r, a_asa, a_asb, a_pcs, a_alu, a_st};
  assign ob = {b_iord, b_mw, b_irw, b_pcen, b_rw, b_rd, b_m2r, b_asa, b_asb, b_pcs, b_alu, b_st};
  assign oc = {c_iord, c_mw, c_irw, c_pcen, c_rw, c_rd, c_m2r, c_asa, c_asb, c_pcs, c_alu, c_st};

  multicycle_ctrl_unit #(.MEM_LAT(1), .EN_BNE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .op_code(op_code), .funct(funct), .zero(zero),
    .iord(a_iord), .memwrite(a_mw), .irwrite(a_irw), .pcen(a_pcen), .regwrite(a_rw),
    .redest(a_rd), .memtoreg(a_m2r), .alusrca(a_asa), .alusrcb(a_asb), .pcsrc(a_pcs),
    .alu_ctrl(a_alu), .state_o(a_st));
  multicycle_ctrl_unit #(.MEM_LAT(1), .EN_BNE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .op_code(op_code), .funct(funct), .zero(zero),
    .iord(b_iord), .memwrite(b_mw), .irwrite(b_irw), .pcen(b_pcen), .regwrite(b_rw),
    .redest(b_rd), .memtoreg(b_m2r), .alusrca(b_asa), .alusrcb(b_asb), .pcsrc(b_pcs),
    .alu_ctrl(b_alu), .state_o(b_st));
  multicycle_ctrl_unit #(.MEM_LAT(3), .EN_BNE(1'b1)) dut_c (
    .clk(clk), .reset(reset), .op_code(op_code), .funct(funct), .zero(zero),
    .iord(c_iord), .memwrite(c_mw), .irwrite(c_irw), .pcen(c_pcen), .regwrite(c_rw),
    .redest(c_rd), .memtoreg(c_m2r), .alusrca(c_asa), .alusrcb(c_asb), .pcsrc(c_pcs),
    .alu_ctrl(c_alu), .state_o(c_st));

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [18:0] e;
  } vec_t;
  vec_t tv[$];
  int checks = 0, errors = 0;

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic [18:0] e);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.e = e;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // one row per clock: drive, settle, compare, advance
  task automatic play(input string tag, input int which);
    for (int i = 0; i < tv.size(); i++) begin
      op_code = tv[i].op; funct = tv[i].fn; zero = tv[i].z;
      #2;
      chk($sformatf("%s[%0d]", tag, i), which == 0 ? oa : which == 1 ? ob : oc, tv[i].e);
      @(posedge clk); #1;
    end
    tv.delete();
  endtask

  initial begin
    #3;
    chk("reset_a", oa, FT0);
    chk("reset_b", ob, FT0);
    chk("reset_c", oc, FT0);
    @(posedge clk); #1;
    chk("reset_hold_a", oa, FT0);
    reset = 1'b0;
    add(6'b100011, 0, 0, FT1); add(6'b100011, 0, 0, DEC); add(6'b100011, 0, 0, MAD);
    add(6'b100011, 0, 0, MRD); add(6'b100011, 0, 0, MWB);
    add(6'b101011, 0, 0, FT1); add(6'b101011, 0, 0, DEC); add(6'b101011, 0, 0, MAD);
    add(6'b101011, 0, 0, MWR1);
    add(0, 6'b100010, 0, FT1); add(0, 6'b100010, 0, DEC); add(0, 6'b100010, 0, EXS);
    add(0, 6'b100010, 0, AWB);
    add(0, 6'b011100, 0, FT1); add(0, 6'b011100, 0, DEC); add(0, 6'b011100, 0, EXT);
    add(0, 6'b011100, 0, AWB);
    add(0, 6'b111111, 0, FT1); add(0, 6'b111111, 0, DEC); add(0, 6'b111111, 0, EXA);
    add(0, 6'b111111, 0, AWB);
    add(6'b001000, 0, 0, FT1); add(6'b001000, 0, 0, DEC); add(6'b001000, 0, 0, AIE);
    add(6'b001000, 0, 0, AIW);
    add(6'b000100, 0, 1, FT1); add(6'b000100, 0, 1, DEC); add(6'b000100, 0, 1, BR1);
    add(6'b000100, 0, 0, FT1); add(6'b000100, 0, 0, DEC); add(6'b000100, 0, 0, BR0);
    add(6'b000101, 0, 1, FT1); add(6'b000101, 0, 1, DEC); add(6'b000101, 0, 1, BR0);
    add(6'b000101, 0, 0, FT1); add(6'b000101, 0, 0, DEC); add(6'b000101, 0, 0, BR1);
    add(6'b000010, 0, 0, FT1); add(6'b000010, 0, 0, DEC); add(6'b000010, 0, 0, JMP);
    add(6'b111111, 0, 0, FT1); add(6'b111111, 0, 0, DEC); add(6'b111111, 0, 0, FT1);
    play("lat1", 0);

    // bne on a core without bne support falls straight back to FETCH
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    op_code = 6'b000101; zero = 1'b0;
    #2 chk("nobne_fetch", ob, FT1);
    @(posedge clk); #3 chk("nobne_decode", ob, DEC);
    @(posedge clk); #3 chk("nobne_back", ob, FT1);
    chk("bne_taken_a", oa, BR1);
    @(posedge clk); #1;

    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    add(6'b101011, 0, 0, FT0); add(6'b101011, 0, 0, FT0); add(6'b101011, 0, 0, FT1);
    add(6'b101011, 0, 0, DEC); add(6'b101011, 0, 0, MAD); add(6'b101011, 0, 0, MWR0);
    add(6'b101011, 0, 0, MWR0); add(6'b101011, 0, 0, MWR1); add(6'b101011, 0, 0, FT0);
    play("sw3", 2);

    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    add(6'b100011, 0, 0, FT0); add(6'b100011, 0, 0, FT0); add(6'b100011, 0, 0, FT1);
    add(6'b100011, 0, 0, DEC); add(6'b100011, 0, 0, MAD); add(6'b100011, 0, 0, MRD);
    play("lw3", 2);
    #2 chk("lw3_memrd2", oc, MRD);
    reset = 1'b1;
    #1 chk("abort_now", oc, FT0);
    chk("abort_now_a", oa, FT0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #3 chk($sformatf("abort_hold%0d", i), oc, FT0);
    end
    @(posedge clk); #1; reset = 1'b0;
    add(6'b100011, 0, 0, FT0); add(6'b100011, 0, 0, FT0); add(6'b100011, 0, 0, FT1);
    add(6'b100011, 0, 0, DEC);
    play("refetch3", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
